// File: rtl/im_fetch_arbiter.sv
// im_fetch_arbiter: round-robin arbiter that lets NUM_C core fetch units share
// one single-ported, synchronous-read instruction memory. It issues at most one
// read per cycle. Each response returns two cycles after its grant, tagged with
// the core that asked for it.

`ifndef NUM_C
`define NUM_C 4
`endif

module im_fetch_arbiter #(
    parameter int unsigned NUM_C     = `NUM_C,
    parameter int unsigned MEM_DEPTH = 1025,
    parameter logic [15:0] OOR_WORD  = 16'd42
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_C-1:0]      req,
    input  logic [NUM_C*16-1:0]   addr,
    output logic [NUM_C-1:0]      gnt,
    output logic [NUM_C-1:0]      rsp_valid,
    output logic [NUM_C*16-1:0]   data_out,
    output logic                  mem_en,
    output logic [15:0]           mem_addr,
    input  logic [15:0]           mem_rdata
);

    localparam int          NC = int'(NUM_C);
    localparam int unsigned PW = (NUM_C > 1) ? $clog2(NUM_C) : 1;

    // Round-robin search pointer: the core checked first in the next arbitration
    logic [PW-1:0]         r_ptr;

    // Stage-1 tag, captured at the grant edge, consumed one cycle later
    logic                  r_s1_valid;
    logic [PW-1:0]         r_s1_id;
    logic                  r_s1_oor;

    // Response stage
    logic [NUM_C-1:0]      r_rsp_valid;
    logic [NUM_C*16-1:0]   r_data;

    // Arbitration results
    logic                  w_found;
    logic [PW-1:0]         w_win;
    logic                  w_gnt_valid;
    logic [15:0]           w_gaddr;
    logic                  w_in_range;
    logic [PW-1:0]         w_ptr_nxt;
    int                    w_idx;

    // Find the first asserted request at or after r_ptr, wrapping modulo NUM_C
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int i = 0; i < NC; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NC) begin
                w_idx = w_idx - NC;
            end
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = PW'(w_idx);
            end
        end
    end

    // Grant, memory request and next pointer; all forced quiet while in reset
    always_comb begin
        w_gnt_valid = w_found && !rst;
        w_gaddr     = addr[int'(w_win)*16 +: 16];
        w_in_range  = (32'(w_gaddr) < MEM_DEPTH);
        gnt         = '0;
        mem_en      = 1'b0;
        mem_addr    = '0;
        if (w_gnt_valid) begin
            gnt[w_win] = 1'b1;
            if (w_in_range) begin
                mem_en   = 1'b1;
                mem_addr = w_gaddr;
            end
        end
        if (int'(w_win) == NC - 1) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_win + PW'(1);
        end
    end

    // Pointer moves just past the winner; unchanged when nobody is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_gnt_valid) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Stage-1 tag capture; out-of-range fetches never touch memory
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_oor   <= 1'b0;
        end else begin
            r_s1_valid <= w_gnt_valid;
            r_s1_id    <= w_win;
            r_s1_oor   <= !w_in_range;
        end
    end

    // One-cycle response strobe for the core named by the stage-1 tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (r_s1_valid) begin
                r_rsp_valid[r_s1_id] <= 1'b1;
            end
        end
    end

    // Only the addressed slice is written; the others hold their last word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (r_s1_valid) begin
            r_data[int'(r_s1_id)*16 +: 16] <= r_s1_oor ? OOR_WORD : mem_rdata;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign data_out  = r_data;

endmodule

// File: tb/tb_im_fetch_arbiter.sv
// Self-checking bench for im_fetch_arbiter: directed scenarios followed by
// randomized traffic, compared every cycle against a transaction-level model.

module tb_im_fetch_arbiter;

    localparam int          NC        = 4;
    localparam int          MEM_DEPTH = 1025;
    localparam logic [15:0] OOR       = 16'd42;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NC-1:0]      req = '0;
    logic [NC*16-1:0]   addr = '0;
    logic [NC-1:0]      gnt;
    logic [NC-1:0]      rsp_valid;
    logic [NC*16-1:0]   data_out;
    logic               mem_en;
    logic [15:0]        mem_addr;
    logic [15:0]        mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    im_fetch_arbiter #(
        .NUM_C     (NC),
        .MEM_DEPTH (MEM_DEPTH),
        .OOR_WORD  (OOR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr      (addr),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .data_out  (data_out),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    // Memory contents: word at a is 3a+3, so memory[5] = 18
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a * 16'd3 + 16'd3;
    endfunction

    // Synchronous-read memory; garbage when not enabled
    always @(posedge clk) begin
        mem_rdata <= mem_en ? mem_word(mem_addr) : 16'hBEEF;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pointer, in-flight fetches with due cycle, visible outputs
    typedef struct {
        int          due;
        int          id;
        logic [15:0] word;
    } fetch_t;

    int            m_ptr;
    int            m_cyc;
    fetch_t        m_q[$];
    logic [NC-1:0] m_rsp;
    logic [15:0]   m_data[NC];
    int            m_wait[NC];

    task automatic model_reset();
        m_ptr = 0;
        m_q.delete();
        m_rsp = '0;
        for (int k = 0; k < NC; k++) begin
            m_data[k] = '0;
            m_wait[k] = 0;
        end
    endtask

    // One clock cycle: drive, check against model, advance model past the edge
    task automatic step(input logic [NC-1:0] rq, input logic [NC*16-1:0] ad,
                        input logic rs, output logic [NC-1:0] seen_gnt);
        int               win;
        logic [15:0]      a;
        logic             in_rng;
        logic [NC-1:0]    exp_gnt;
        logic [NC*16-1:0] exp_data;
        logic             starved;
        fetch_t           f;
        @(negedge clk);
        req  = rq;
        addr = ad;
        rst  = rs;
        if (rs) model_reset();
        #1;
        win = -1;
        if (!rs) begin
            for (int k = 0; k < NC; k++) begin
                int c;
                c = (m_ptr + k) % NC;
                if (win < 0 && rq[c]) win = c;
            end
        end
        exp_gnt = '0;
        a       = '0;
        if (win >= 0) begin
            exp_gnt[win] = 1'b1;
            a = ad[win*16 +: 16];
        end
        in_rng = (int'(a) < MEM_DEPTH);
        check_eq("gnt", 64'(gnt), 64'(exp_gnt));
        check_eq("mem_en", 64'(mem_en), 64'(win >= 0 && in_rng));
        check_eq("mem_addr", 64'(mem_addr), 64'((win >= 0 && in_rng) ? a : 16'd0));
        for (int k = 0; k < NC; k++) exp_data[k*16 +: 16] = m_data[k];
        check_eq("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
        check_eq("data_out", 64'(data_out), 64'(exp_data));
        // Held requests must be served within NUM_C-1 waiting cycles
        starved = 1'b0;
        for (int k = 0; k < NC; k++) begin
            if (!rs && rq[k] && !gnt[k]) m_wait[k]++;
            else m_wait[k] = 0;
            if (m_wait[k] > NC - 1) starved = 1'b1;
        end
        check_eq("max_wait", 64'(starved), 64'(0));
        seen_gnt = gnt;
        @(posedge clk);
        m_cyc++;
        if (!rs && win >= 0) begin
            f.due  = m_cyc + 1;
            f.id   = win;
            f.word = in_rng ? mem_word(a) : OOR;
            m_q.push_back(f);
            m_ptr = (win + 1) % NC;
        end
        m_rsp = '0;
        if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
            f = m_q.pop_front();
            m_rsp[f.id]  = 1'b1;
            m_data[f.id] = f.word;
        end
    endtask

    function automatic logic [15:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0:       return 16'(MEM_DEPTH - 1);
            1:       return 16'(MEM_DEPTH);
            2:       return 16'($urandom_range(MEM_DEPTH + 1, 65535));
            3:       return 16'd0;
            default: return 16'($urandom_range(0, MEM_DEPTH - 2));
        endcase
    endfunction

    logic [NC-1:0]    g;
    logic [NC-1:0]    last_gnt;
    logic [NC-1:0]    cur_req;
    logic [15:0]      cur_addr[NC];
    logic [NC*16-1:0] packed_addr;

    initial begin
        m_cyc = 0;
        model_reset();

        // Reset then idle
        step('0, '0, 1'b1, g);
        step('0, '0, 1'b1, g);
        for (int i = 0; i < 10; i++) step('0, '0, 1'b0, g);

        // Single fetch: core 2, address 5
        step(4'b0100, {16'd0, 16'd5, 16'd0, 16'd0}, 1'b0, g);
        check_eq("t2_gnt", 64'(g), 64'(4'b0100));
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, g);

        // Full contention from ptr=0
        step('0, '0, 1'b1, g);
        for (int i = 0; i < 8; i++) begin
            logic [NC-1:0] eg;
            step(4'b1111, {16'd3, 16'd2, 16'd1, 16'd0}, 1'b0, g);
            eg = '0;
            eg[i % NC] = 1'b1;
            check_eq("t3_order", 64'(g), 64'(eg));
        end
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, g);

        // Cores 1 and 3 only, from ptr=0; core 3 sits exactly at the last valid address
        step('0, '0, 1'b1, g);
        for (int i = 0; i < 8; i++) begin
            step(4'b1010, {16'd1024, 16'd0, 16'd100, 16'd0}, 1'b0, g);
            check_eq("t4_alt", 64'(g), 64'((i % 2 == 0) ? 4'b0010 : 4'b1000));
        end
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, g);

        // Out-of-range fetch on core 0
        step('0, '0, 1'b1, g);
        step(4'b0001, {16'd0, 16'd0, 16'd0, 16'd2000}, 1'b0, g);
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, g);

        // Reset while a fetch for core 1 is in flight
        step(4'b0010, {16'd0, 16'd0, 16'd7, 16'd0}, 1'b0, g);
        step('0, '0, 1'b1, g);
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, g);
        step(4'b1010, {16'd9, 16'd0, 16'd8, 16'd0}, 1'b0, g);
        check_eq("t6_first", 64'(g), 64'(4'b0010));
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, g);

        // Randomized traffic obeying the hold-until-grant handshake
        last_gnt = '1;
        cur_req  = '0;
        for (int k = 0; k < NC; k++) cur_addr[k] = '0;
        for (int n = 0; n < 400; n++) begin
            logic rs;
            rs = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < NC; k++) begin
                if (!(cur_req[k] && !last_gnt[k])) begin
                    cur_req[k]  = ($urandom_range(0, 2) != 0);
                    cur_addr[k] = pick_addr();
                end
                packed_addr[k*16 +: 16] = cur_addr[k];
            end
            step(cur_req, packed_addr, rs, last_gnt);
            if (rs) last_gnt = '1;
        end
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, g);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
